pipe_stage_elastic: RTL and testbench

//   Generic elastic pipeline stage register that replaces the fixed IF/ID..MEM/WB latches.
//   It uses a valid/ready handshake on both sides and an optional 2-entry skid buffer.
//   It supports synchronous flush (squash), external hold (stall) and halt-flag propagation,
//   and counts squashed entries for performance analysis.
//   One instance sits between each pair of CPU pipe stages; DATA_W carries the stage's packed bundle.

---
 rtl/pipe_stage_elastic.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Elastic valid/ready pipeline stage with optional 2-entry skid
//               buffer, flush, hold, halt propagation and saturating flush count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_elastic #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_halt,
    input  logic              hold,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   w_main_data_nxt;
    logic                r_main_halt;
    logic                w_main_halt_nxt;
    logic [DATA_W-1:0]   r_skid_data;
    logic [DATA_W-1:0]   w_skid_data_nxt;
    logic                r_skid_halt;
    logic                w_skid_halt_nxt;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [CNT_W-1:0]    w_flush_cnt_nxt;

    logic                w_out_valid;
    logic                w_in_ready;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_in_halt_q;
    logic [1:0]          w_discard;
    logic [CNT_W:0]      w_cnt_sum;

    // Output side only looks at registered state and hold, never out_ready.
    assign w_out_valid = (r_state != S_EMPTY) && !hold;

    generate
        if (SKID) begin : g_skid
            assign w_in_ready = (r_state != S_FULL) && !hold;
        end else begin : g_single
            assign w_in_ready = (!w_out_valid || out_ready) && !hold;
        end
    endgenerate

    assign w_in_xfer   = in_valid && w_in_ready;
    assign w_out_xfer  = w_out_valid && out_ready;
    assign w_in_halt_q = in_halt && in_valid;

    // An entry leaving on the flush edge was consumed, so it is not counted.
    assign w_discard = occupancy - {1'b0, w_out_xfer};
    assign w_cnt_sum = {1'b0, r_flush_cnt} + (CNT_W+1)'(w_discard);

    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_halt_nxt = r_main_halt;
        w_skid_data_nxt = r_skid_data;
        w_skid_halt_nxt = r_skid_halt;
        w_flush_cnt_nxt = r_flush_cnt;

        if (flush) begin
            w_state_nxt     = S_EMPTY;
            w_main_data_nxt = NOP_DATA;
            w_main_halt_nxt = 1'b0;
            w_flush_cnt_nxt = w_cnt_sum[CNT_W] ? c_cnt_max : w_cnt_sum[CNT_W-1:0];
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt     = S_ONE;
                        w_main_data_nxt = in_data;
                        w_main_halt_nxt = w_in_halt_q;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && !w_out_xfer && SKID) begin
                        w_state_nxt     = S_FULL;
                        w_skid_data_nxt = in_data;
                        w_skid_halt_nxt = w_in_halt_q;
                    end else if (w_in_xfer && w_out_xfer) begin
                        w_main_data_nxt = in_data;
                        w_main_halt_nxt = w_in_halt_q;
                    end else if (w_out_xfer) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt     = S_ONE;
                        w_main_data_nxt = r_skid_data;
                        w_main_halt_nxt = r_skid_halt;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_EMPTY;
            r_main_data <= NOP_DATA;
            r_main_halt <= 1'b0;
            r_skid_data <= NOP_DATA;
            r_skid_halt <= 1'b0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_halt <= w_main_halt_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_halt <= w_skid_halt_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = (r_state != S_EMPTY) ? r_main_data : NOP_DATA;
    assign out_halt  = r_main_halt && w_out_valid;
    assign occupancy = r_state;
    assign flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
// ============================================================================
// Module      : tb_pipe_stage_elastic
// Description : Scoreboard bench driving a SKID=1 (CNT_W=2) and a SKID=0 stage
//               with shared stimulus, each checked against a FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_elastic;

    localparam logic [31:0] c_nop = 32'h0;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_halt = 1'b0;
    logic        out_ready = 1'b0;
    logic        hold = 1'b0;
    logic        flush = 1'b0;

    logic [1:0]  ir_v;
    logic [1:0]  ov_v;
    logic [1:0]  oh_v;
    logic [31:0] od_v [2];
    logic [1:0]  occ_v [2];
    logic [1:0]  fc0;
    logic [15:0] fc1;

    int checks = 0;
    int errors = 0;

    // Model: each stage is a FIFO of {halt, data} with a fixed capacity.
    logic [32:0] q [2][$];
    int          cnt [2];
    int          cmax [2] = '{3, 65535};
    int          cap [2]  = '{2, 1};
    logic        exp_ir [2];

    always #5 CLK = ~CLK;

    pipe_stage_elastic #(.DATA_W(32), .NOP_DATA(c_nop), .SKID(1'b1), .CNT_W(2)) u_dut_skid (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_v[0]),
        .in_data(in_data), .in_halt(in_halt), .out_valid(ov_v[0]),
        .out_ready(out_ready), .out_data(od_v[0]), .out_halt(oh_v[0]),
        .hold(hold), .flush(flush), .occupancy(occ_v[0]), .flush_cnt(fc0)
    );

    pipe_stage_elastic #(.DATA_W(32), .NOP_DATA(c_nop), .SKID(1'b0), .CNT_W(16)) u_dut_single (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(ir_v[1]),
        .in_data(in_data), .in_halt(in_halt), .out_valid(ov_v[1]),
        .out_ready(out_ready), .out_data(od_v[1]), .out_halt(oh_v[1]),
        .hold(hold), .flush(flush), .occupancy(occ_v[1]), .flush_cnt(fc1)
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at %0t: got 0x%08h expected 0x%08h", name, k, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive at posedge, check static outputs, update model at negedge.
    task automatic cycle(input logic rst_v, input logic iv, input logic [31:0] id, input logic ih,
                         input logic ordy, input logic hd, input logic fl);
        @(posedge CLK);
        RST = rst_v; in_valid = iv; in_data = id; in_halt = ih;
        out_ready = ordy; hold = hd; flush = fl;
        if (!rst_v) begin
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                cnt[k] = 0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            if (cap[k] == 2)
                exp_ir[k] = !hd && (q[k].size() < 2);
            else
                exp_ir[k] = !hd && (q[k].size() == 0 || ordy);
            chk("in_ready", k, {31'b0, ir_v[k]}, {31'b0, exp_ir[k]});
            chk("occupancy", k, {30'b0, occ_v[k]}, q[k].size());
            chk("flush_cnt", k, (k == 0) ? {30'b0, fc0} : {16'b0, fc1}, cnt[k]);
        end
        @(negedge CLK);
        if (rst_v) begin
            for (int k = 0; k < 2; k++) begin
                if (fl) begin
                    cnt[k] = cnt[k] + q[k].size();
                    if (cnt[k] > cmax[k]) cnt[k] = cmax[k];
                    q[k].delete();
                end else if (iv && exp_ir[k]) begin
                    q[k].push_back({ih, id});
                end
            end
        end
    endtask

    // Monitor: compares the head presented by each DUT and retires it on transfer.
    initial begin
        logic        ev;
        logic [31:0] ed;
        logic        eh;
        forever begin
            @(posedge CLK);
            #2;
            for (int k = 0; k < 2; k++) begin
                ev = (q[k].size() > 0) && !hold;
                ed = (q[k].size() > 0) ? q[k][0][31:0] : c_nop;
                eh = ev ? q[k][0][32] : 1'b0;
                chk("out_valid", k, {31'b0, ov_v[k]}, {31'b0, ev});
                chk("out_data", k, od_v[k], ed);
                chk("out_halt", k, {31'b0, oh_v[k]}, {31'b0, eh});
                if (ev && out_ready) void'(q[k].pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        // Single entry with downstream ready.
        cycle(1, 1, 32'h0000_0013, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 1, 0, 0);
        // Fill the skid buffer, then drain.
        cycle(1, 1, 32'hAAAA_0001, 0, 0, 0, 0);
        cycle(1, 1, 32'hBBBB_0002, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0, 0);
        // Flush a full stage with an input presented on the flush edge.
        cycle(1, 1, 32'h1111_0001, 0, 0, 0, 0);
        cycle(1, 1, 32'h1111_0002, 0, 0, 0, 0);
        cycle(1, 1, 32'h1111_0003, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        // Hold for five cycles with traffic offered on both sides.
        cycle(1, 1, 32'h2222_0001, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h2222_1000 + i, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h2222_2000 + i, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 0);
        // Repeated flushes of a full stage drive the 2-bit counter to saturation.
        for (int r = 0; r < 3; r++) begin
            cycle(1, 1, 32'h3333_0000 + r, 0, 0, 0, 0);
            cycle(1, 1, 32'h3333_1000 + r, 1, 0, 0, 0);
            cycle(1, 0, 0, 0, 0, 1, 1);
        end
        // Flush with a simultaneous output transfer, then flush while empty.
        cycle(1, 1, 32'h4444_0001, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 1, 0, 1);
        // Randomised stream, out_ready toggling every 3 cycles, reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            logic rv;
            rv = !(i >= 200 && i < 202);
            cycle(rv, ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 1),
                  ((i / 3) % 2) == 0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 1, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
